// File: rtl/btn_debounce_rx.sv
// Button receiver: two-flop synchroniser, debounce FSM, press/release pulses and press counter.
// Optional long-press pulse enabled by defining BTN_LONG_PRESS_EN.
module btn_debounce_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             BTN_IN,
  output logic             BTN_LEVEL,
  output logic             BTN_PRESS,
  output logic             BTN_RELEASE,
  output logic [CNT_W-1:0] PRESS_CNT,
  output logic             BTN_LONG
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_chk
    $error("btn_debounce_rx: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_WAIT  = 2'd1,
    PRESSED = 2'd2,
    R_WAIT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      state_q     <= IDLE;
      sync_q      <= 2'b00;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // Next-state: a transition is accepted only after DEBOUNCE_CYCLES+1 agreeing samples.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], BTN_IN};
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = P_WAIT;
          cnt_d   = DB_W'(1);
        end
      end
      P_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          press_cnt_d = press_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = R_WAIT;
          cnt_d   = DB_W'(1);
        end
      end
      R_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;
  assign PRESS_CNT   = press_cnt_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LG_W = $clog2(LONG_CYCLES + 1);

  logic [LG_W-1:0] long_cnt_q, long_cnt_d;
  logic            long_q, long_d;

  always_ff @(posedge CLK) begin
    if (RST_X) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  // Held-time counter saturates at LONG_CYCLES so the pulse fires once per press.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (state_q == IDLE) begin
      long_cnt_d = '0;
    end else if (state_q == P_WAIT && state_d == PRESSED) begin
      long_cnt_d = '0;
    end else if ((state_q == PRESSED || state_q == R_WAIT) &&
                 long_cnt_q != LG_W'(LONG_CYCLES)) begin
      long_cnt_d = long_cnt_q + LG_W'(1);
      long_d     = (long_cnt_q == LG_W'(LONG_CYCLES - 1));
    end
  end

  assign BTN_LONG = long_q;
`else
  assign BTN_LONG = 1'b0;
`endif

endmodule

// File: doc/btn_debounce_rx.md
Name: btn_debounce_rx

Overview:
- Input-side counterpart of the board LED drivers.
- Receives one raw, asynchronous push-button/switch line and synchronises it to CLK.
- Debounces it with a state machine and presents clean level, press/release pulses and a press counter to downstream logic (LEDG drivers, mode selects).
- One instance per physical button. Sits directly behind the board pin.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a transition; legal range is 1 or greater.
- LONG_CYCLES, 64: held-pressed cycles before BTN_LONG fires (optional feature only); legal range is 1 or greater.
- CNT_W, 8: width of PRESS_CNT.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RST_X  in  1  reset, synchronous, active-high.
- BTN_IN  in  1  raw button level, asynchronous, 1 = pressed.
- BTN_LEVEL  out  1  debounced level, registered.
- BTN_PRESS  out  1  one-cycle pulse on accepted press.
- BTN_RELEASE  out  1  one-cycle pulse on accepted release.
- PRESS_CNT  out  CNT_W  count of accepted presses, wraps.
- BTN_LONG  out  1  one-cycle long-press pulse; tied 0 when the feature is disabled.

Behaviour:
- Synchroniser: two flops on BTN_IN produce sync signal s. Both flops clear to 0 on reset.
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1).
- Reset values: FSM = IDLE, counters 0, all outputs 0. Reset has priority over every other event, including mid-debounce or mid-press. No pulse is emitted on reset or on reset release.
- FSM states and transitions:
  - IDLE: if s=1, go to P_WAIT with cnt=1; otherwise stay.
  - P_WAIT:
    - If s=0, return to IDLE, clear cnt, no pulse (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES, go to PRESSED: BTN_LEVEL<=1, BTN_PRESS<=1 for one cycle, PRESS_CNT<=PRESS_CNT+1.
    - Else cnt++.
  - PRESSED: if s=0, go to R_WAIT with cnt=1; otherwise stay.
  - R_WAIT:
    - If s=1, return to PRESSED, clear cnt, no pulse.
    - Else if cnt==DEBOUNCE_CYCLES, go to IDLE: BTN_LEVEL<=0, BTN_RELEASE<=1 for one cycle.
    - Else cnt++.
- Latency: BTN_IN rises before edge E1 and stays high. BTN_LEVEL and BTN_PRESS are high after edge E(DEBOUNCE_CYCLES+3); BTN_PRESS drops after the next edge. Release latency is identical.
- BTN_LEVEL does not change during P_WAIT or R_WAIT.
- BTN_PRESS and BTN_RELEASE are never high in the same cycle.
- Minimum pulse spacing is 2*(DEBOUNCE_CYCLES+1) cycles.
- PRESS_CNT wraps from 2^CNT_W-1 to 0 with no flag. It increments only on accepted presses.
- If the button is held through reset release, the block debounces again from IDLE and produces one BTN_PRESS.
- A glitch of DEBOUNCE_CYCLES or fewer synchronised cycles produces no output activity.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- When defined:
  - A held counter, width clog2(LONG_CYCLES+1), clears on entry to PRESSED and increments each cycle in PRESSED or R_WAIT.
  - When it reaches LONG_CYCLES, BTN_LONG pulses high for one cycle and the counter saturates, so BTN_LONG fires once per press.
  - A bounce back from R_WAIT to PRESSED does not clear the counter.
  - The counter clears in IDLE and on reset.
- When undefined: no long-press counter is built; BTN_LONG is constant 0. All other behaviour is unchanged.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, CNT_W=8: reset, then BTN_IN=1 before edge E1 and held. Required: BTN_LEVEL=1 and BTN_PRESS=1 after E7 only; PRESS_CNT=1; BTN_RELEASE stays 0.
- Bounce rejection, DEBOUNCE_CYCLES=4: BTN_IN high 3 cycles, low 2, high 2, then low. Required: no BTN_PRESS, BTN_LEVEL=0, PRESS_CNT=0.
- Release: after an accepted press, BTN_IN=0 held. Required: BTN_RELEASE high for exactly one cycle, DEBOUNCE_CYCLES+3 edges after the drop; BTN_LEVEL=0.
- Counter wrap, CNT_W=2: 5 clean press/release pairs. Required: PRESS_CNT reads 1, 2, 3, 0, 1.
- Reset mid-press: assert RST_X for 1 cycle while in PRESSED with BTN_IN held. Required: all outputs 0 after the reset edge, no BTN_RELEASE, then a new BTN_PRESS DEBOUNCE_CYCLES+3 edges after reset release with PRESS_CNT=1.
- With BTN_LONG_PRESS_EN, LONG_CYCLES=10, DEBOUNCE_CYCLES=4: hold the button 30 cycles after BTN_PRESS. Required: BTN_LONG is a single one-cycle pulse 10 cycles after entering PRESSED. Without the macro, BTN_LONG stays 0.
